// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types, including the data-memory responder FSM state.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between a requester (master) and the responder (slave).
interface dmem_responder_if;
  import rv32i_types::*;

  rv32i_word dmem_addr;
  rv32i_mask dmem_rmask;
  rv32i_mask dmem_wmask;
  rv32i_word dmem_wdata;
  rv32i_word dmem_rdata;
  logic      dmem_resp;
  logic      dmem_err;
  logic      busy;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp, dmem_err, busy
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp, dmem_err, busy
  );

endinterface

// File: rtl/dmem_word_array.sv
// Word-organised backing store with per-byte write enables and combinational read.
module dmem_word_array
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  rv32i_mask        be,
  input  logic [IDX_W-1:0] idx,
  input  rv32i_word        wdata,
  output rv32i_word        rdata
);

  // Contents are deliberately not reset so data survives a responder reset.
  rv32i_word mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: captures one request, waits LATENCY cycles,
// then completes it against dmem_word_array with a one-cycle dmem_resp pulse.
//
//   state | meaning
//   IDLE  | no request held; capture the next one with a nonzero mask
//   WAIT  | request captured, latency counter running down
//   RESP  | dmem_resp pulse; write commits, read data presented
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  dmem_resp_state_t state_q, state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_dec;
  rv32i_word        addr_q, wdata_q;
  rv32i_mask        rmask_q, wmask_q;
  rv32i_word        rdata_q, rdata_d;
  rv32i_word        word_idx;
  rv32i_word        mem_rdata;
  logic             req_valid, capture;
  logic             is_read, is_write, illegal;
  logic             resp, err, mem_we;

  assign req_valid = (|bus.dmem_rmask) | (|bus.dmem_wmask);
  assign capture   = (state_q == IDLE) && req_valid;
  assign cnt_dec   = cnt_q - 4'd1;

  // Decode works only from the captured copy; live inputs matter only at capture.
  assign word_idx = (addr_q - BASE_ADDR) >> 2;
  assign is_read  = |rmask_q;
  assign is_write = |wmask_q;
  assign illegal  = (addr_q[1:0] != 2'b00) || (word_idx >= DEPTH_WORDS) || (is_read && is_write);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_dec == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp    = 1'b0;
    err     = 1'b0;
    mem_we  = 1'b0;
    rdata_d = rdata_q;
    if ((state_q == RESP) && !rst) begin
      resp   = 1'b1;
      err    = illegal;
      mem_we = is_write && !illegal;
      if (illegal)      rdata_d = '0;
      else if (is_read) rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  cnt_q <= '0;
    else if (capture)         cnt_q <= LAT_LOAD;
    else if (state_q == WAIT) cnt_q <= cnt_dec;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= bus.dmem_addr;
      rmask_q <= bus.dmem_rmask;
      wmask_q <= bus.dmem_wmask;
      wdata_q <= bus.dmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (wmask_q),
    .idx  (word_idx[IDX_W-1:0]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign bus.dmem_resp  = resp;
  assign bus.dmem_err   = err;
  assign bus.dmem_rdata = rdata_d;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven with directed and random
// requests; expectations come from a word-array reference model and timing rules.
module tb_dmem_responder;

  localparam int          LAT0  = 2;
  localparam int          LAT1  = 1;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   b2b = 1'b0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  dmem_responder_if u_if0();
  dmem_responder_if u_if1();

  dmem_responder #(.LATENCY(LAT0), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(u_if0)
  );
  dmem_responder #(.LATENCY(LAT1), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(u_if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    if (sel == 0) begin
      u_if0.dmem_addr = a; u_if0.dmem_rmask = rm; u_if0.dmem_wmask = wm; u_if0.dmem_wdata = wd;
    end else begin
      u_if1.dmem_addr = a; u_if1.dmem_rmask = rm; u_if1.dmem_wmask = wm; u_if1.dmem_wdata = wd;
    end
  endtask

  // Reference behaviour: word index, legality, lane merge, held read data.
  task automatic model(input int sel, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd, output exp_t e);
    logic [31:0] idx, w, last;
    bit ill;
    idx  = (a - BASE) >> 2;
    ill  = (a[1:0] != 2'b00) || (idx >= DEPTH) || (rm != 4'h0 && wm != 4'h0);
    last = (sel == 0) ? last0 : last1;
    w    = '0;
    if (!ill) w = (sel == 0) ? mem0[idx[5:0]] : mem1[idx[5:0]];
    e.err = ill;
    if (ill) begin
      e.rdata = '0;
      last    = '0;
    end else if (wm != 4'h0) begin
      for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
      if (sel == 0) mem0[idx[5:0]] = w; else mem1[idx[5:0]] = w;
      e.rdata = last;
    end else begin
      e.rdata = w;
      last    = w;
    end
    if (sel == 0) last0 = last; else last1 = last;
  endtask

  // Called just after a negedge; b2b means the DUT is in its response cycle right now.
  task automatic issue(input int sel, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    exp_t e;
    int lat;
    lat = (sel == 0) ? LAT0 : LAT1;
    drive(sel, a, rm, wm, wd);
    model(sel, a, rm, wm, wd, e);
    e.cyc = cyc + (b2b ? 2 : 1) + lat - 1;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    while (cyc < e.cyc) @(negedge clk);
    b2b = 1'b1;
  endtask

  task automatic gap(input int sel, input int n);
    drive(sel, 32'h0, 4'h0, 4'h0, 32'h0);
    repeat (n) @(negedge clk);
    b2b = 1'b0;
  endtask

  task automatic run_random(input int sel, input int n);
    logic [31:0] a;
    logic [3:0]  rm, wm;
    int r;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 9);
      a  = BASE + ($urandom_range(0, DEPTH - 1) << 2);
      rm = 4'h0;
      wm = 4'h0;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = BASE + 32'(DEPTH * 4) + ($urandom_range(0, 15) << 2);
      if (r == 2) begin
        rm = 4'($urandom_range(1, 15));
        wm = 4'($urandom_range(1, 15));
      end else if ($urandom_range(0, 1) == 0) rm = 4'($urandom_range(1, 15));
      else wm = 4'($urandom_range(1, 15));
      issue(sel, a, rm, wm, $urandom);
      if ($urandom_range(0, 2) != 0) gap(sel, $urandom_range(1, 2));
    end
  endtask

  task automatic mon(input int sel, input logic resp, input logic err, input logic busy,
                     input logic [31:0] rdata);
    exp_t e;
    bit have;
    have = (sel == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (sel == 0) ? q0[0] : q1[0];
    if (have && e.cyc == cyc) begin
      if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("dut%0d resp cyc%0d", sel, cyc), {31'b0, resp}, 32'd1);
      chk($sformatf("dut%0d err cyc%0d", sel, cyc), {31'b0, err}, {31'b0, e.err});
      chk($sformatf("dut%0d rdata cyc%0d", sel, cyc), rdata, e.rdata);
      chk($sformatf("dut%0d busy cyc%0d", sel, cyc), {31'b0, busy}, 32'd1);
    end else if (resp !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_resp cyc%0d: resp=%b required 0", sel, cyc, resp);
    end
  endtask

  always @(negedge clk) mon(0, u_if0.dmem_resp, u_if0.dmem_err, u_if0.busy, u_if0.dmem_rdata);
  always @(negedge clk) mon(1, u_if1.dmem_resp, u_if1.dmem_err, u_if1.busy, u_if1.dmem_rdata);

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
    drive(1, 32'h0, 4'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("rst resp0", {31'b0, u_if0.dmem_resp}, 32'd0);
    chk("rst err0", {31'b0, u_if0.dmem_err}, 32'd0);
    chk("rst rdata0", u_if0.dmem_rdata, 32'd0);
    chk("rst busy0", {31'b0, u_if0.busy}, 32'd0);
    chk("rst resp1", {31'b0, u_if1.dmem_resp}, 32'd0);
    chk("rst busy1", {31'b0, u_if1.busy}, 32'd0);
    chk("rst rdata1", u_if1.dmem_rdata, 32'd0);

    // Prefill every word so later reads never hit uninitialised storage.
    for (int i = 0; i < DEPTH; i++) issue(0, BASE + 32'(i * 4), 4'h0, 4'hF, $urandom);
    gap(0, 1);

    issue(0, 32'h10, 4'h0, 4'hF, 32'hDEADBEEF);
    gap(0, 1);
    issue(0, 32'h10, 4'hF, 4'h0, 32'h0);
    issue(0, 32'h20, 4'h0, 4'hF, 32'h11223344);
    issue(0, 32'h20, 4'h0, 4'b0100, 32'h00AA0000);
    issue(0, 32'h20, 4'h1, 4'h0, 32'h0);
    issue(0, 32'h12, 4'hF, 4'h0, 32'h0);
    issue(0, 32'h10, 4'hF, 4'h0, 32'h0);
    issue(0, BASE + 32'(DEPTH * 4), 4'hF, 4'h0, 32'h0);
    issue(0, BASE - 32'd4, 4'hF, 4'h0, 32'h0);
    issue(0, 32'h10, 4'h3, 4'h0, 32'h0);
    issue(0, 32'h14, 4'hF, 4'hF, 32'h0);
    gap(0, 2);

    // Write abandoned by reset in WAIT: no response, storage unchanged, rdata cleared.
    drive(0, 32'h30, 4'h0, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    chk("wait busy0", {31'b0, u_if0.busy}, 32'd1);
    rst0 = 1'b1;
    drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    chk("midrst busy0", {31'b0, u_if0.busy}, 32'd0);
    chk("midrst rdata0", u_if0.dmem_rdata, 32'd0);
    last0 = '0;
    gap(0, 1);
    issue(0, 32'h30, 4'hF, 4'h0, 32'h0);
    gap(0, 1);

    run_random(0, 150);
    gap(0, 3);

    for (int i = 0; i < DEPTH; i++) issue(1, BASE + 32'(i * 4), 4'h0, 4'hF, $urandom);
    gap(1, 1);
    issue(1, 32'h0, 4'hF, 4'h0, 32'h0);
    issue(1, 32'h4, 4'hF, 4'h0, 32'h0);
    issue(1, 32'h0, 4'hF, 4'h0, 32'h0);
    issue(1, 32'h8, 4'h0, 4'b1001, 32'hA5000077);
    issue(1, 32'h8, 4'hF, 4'h0, 32'h0);
    gap(1, 1);
    run_random(1, 150);
    gap(1, 4);

    chk("drain q0", 32'(q0.size()), 32'd0);
    chk("drain q1", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
